// File: rtl/msx_wait_pkg.sv
// Shared types and defaults for the Z80 wait-state generator.
// Access classes, FSM states and the MSX1 default wait counts.
package msx_wait_pkg;

  typedef enum logic [2:0] {
    ACC_NONE = 3'd0,
    ACC_M1   = 3'd1,
    ACC_MEM  = 3'd2,
    ACC_IO   = 3'd3,
    ACC_VDP  = 3'd4
  } acc_class_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } wait_state_t;

  localparam int unsigned DEF_WAIT_M1  = 1;
  localparam int unsigned DEF_WAIT_MEM = 0;
  localparam int unsigned DEF_WAIT_IO  = 0;
  localparam int unsigned DEF_WAIT_VDP = 0;

endpackage

// File: rtl/msx_wait_gen_gap_timer.sv
// Saturating clk21m timer measuring time since the last VDP access ended.
// Resets saturated so the first VDP access after reset pays no penalty.
module msx_wait_gap_timer #(
  parameter int GAP_W = 7
) (
  input  logic             clk21m,
  input  logic             reset,
  input  logic             clr,
  input  logic [GAP_W-1:0] limit,
  output logic             done
);

  logic [GAP_W-1:0] cnt_q;
  logic [GAP_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (cnt_q != '1)
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk21m or posedge reset) begin
    if (reset)
      cnt_q <= '1;
    else
      cnt_q <= cnt_d;
  end

  assign done = (cnt_q >= limit);

endmodule

// File: rtl/msx_wait_gen.sv
// Configurable Z80 wait-state generator between the T80 core and bus decoders.
// Per-class wait counts, VDP access spacing and slot ext_wait_n merge.
module msx_wait_gen
  import msx_wait_pkg::*;
#(
  parameter int         WAIT_W   = 3,
  parameter int         GAP_W    = 7,
  parameter logic [7:0] VDP_PORT = 8'h98
) (
  input  logic              clk21m,
  input  logic              reset,
  input  logic              ce_p,
  input  logic              m1_n,
  input  logic              mreq_n,
  input  logic              iorq_n,
  input  logic              rd_n,
  input  logic              wr_n,
  input  logic              rfsh_n,
  input  logic [7:0]        a,
  input  logic              ext_wait_n,
  input  logic              cfg_en,
  input  logic [WAIT_W-1:0] cfg_wait_m1,
  input  logic [WAIT_W-1:0] cfg_wait_mem,
  input  logic [WAIT_W-1:0] cfg_wait_io,
  input  logic [WAIT_W-1:0] cfg_wait_vdp,
  input  logic [GAP_W-1:0]  cfg_vdp_gap,
  output logic              wait_n,
  output logic [2:0]        acc_class
);

  logic acc;
  logic start;
  logic is_vdp;
  logic gap_clr;
  logic gap_done;

  acc_class_t        cls_now;
  logic [WAIT_W-1:0] cfg_sel;

  wait_state_t       state_q, state_d;
  acc_class_t        cls_q, cls_d;
  logic [WAIT_W-1:0] cnt_q, cnt_d;
  logic              pend_q, pend_d;
  logic              wait_q, wait_d;
  logic              acc_d_q;

  // Refresh and interrupt acknowledge never qualify as accesses.
  assign acc = (~mreq_n & rfsh_n & (~m1_n | ~rd_n | ~wr_n))
             | (~iorq_n & m1_n & (~rd_n | ~wr_n));
  assign start  = acc & ~acc_d_q;
  assign is_vdp = (((a ^ VDP_PORT) & 8'hFC) == 8'h00);

  always_comb begin
    if (~m1_n)
      cls_now = ACC_M1;
    else if (~mreq_n)
      cls_now = ACC_MEM;
    else if (is_vdp)
      cls_now = ACC_VDP;
    else
      cls_now = ACC_IO;
  end

  always_comb begin
    unique case (cls_now)
      ACC_M1:  cfg_sel = cfg_wait_m1;
      ACC_MEM: cfg_sel = cfg_wait_mem;
      ACC_VDP: cfg_sel = cfg_wait_vdp;
      default: cfg_sel = cfg_wait_io;
    endcase
  end

  assign gap_clr = acc_d_q & ~acc & (cls_q == ACC_VDP);

  msx_wait_gap_timer #(
    .GAP_W(GAP_W)
  ) u_gap (
    .clk21m(clk21m),
    .reset (reset),
    .clr   (gap_clr),
    .limit (cfg_vdp_gap),
    .done  (gap_done)
  );

  always_comb begin
    state_d = state_q;
    cls_d   = cls_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    wait_d  = wait_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          cls_d  = cls_now;
          cnt_d  = cfg_sel;
          pend_d = (cls_now == ACC_VDP) & ~gap_done & cfg_en;
          if (cfg_en & ((cfg_sel != '0) | pend_d)) begin
            wait_d  = 1'b0;
            state_d = WAIT;
          end else begin
            state_d = HOLD;
          end
        end
      end
      WAIT: begin
        if (~acc) begin
          wait_d  = 1'b1;
          state_d = IDLE;
        end else begin
          if (ce_p && (cnt_q != '0))
            cnt_d = cnt_q - 1'b1;
          if (gap_done)
            pend_d = 1'b0;
          if ((cnt_q == '0) && (~pend_q | gap_done)) begin
            wait_d  = 1'b1;
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (~acc)
          state_d = IDLE;
      end
      default: begin
        wait_d  = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk21m or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cls_q   <= ACC_NONE;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      wait_q  <= 1'b1;
      acc_d_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      wait_q  <= wait_d;
      acc_d_q <= acc;
    end
  end

  assign wait_n    = wait_q & ext_wait_n;
  assign acc_class = cls_q;

endmodule

// File: tb/tb_msx_wait_gen.sv
// Self-checking bench for msx_wait_gen: vector table, corner sequences
// and randomized accesses against a wait-count reference model.
module tb_msx_wait_gen;

  logic       clk21m = 1'b0;
  logic       reset;
  logic       ce_p;
  logic       m1_n, mreq_n, iorq_n, rd_n, wr_n, rfsh_n;
  logic [7:0] a;
  logic       ext_wait_n;
  logic       cfg_en;
  logic [2:0] cfg_wait_m1, cfg_wait_mem, cfg_wait_io, cfg_wait_vdp;
  logic [6:0] cfg_vdp_gap;
  logic       wait_n;
  logic [2:0] acc_class;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef enum int {
    K_M1, K_MEMRD, K_MEMWR, K_IORD, K_IOWR, K_VDP, K_RFSH, K_INTA
  } kind_e;

  typedef struct {
    kind_e k;
    int    cfgv;
    bit    en;
    int    ext;
    int    per;
    int    exp_lows;
    int    exp_cls;
    string name;
  } vec_t;

  vec_t tbl[11];

  msx_wait_gen dut (
    .clk21m      (clk21m),
    .reset       (reset),
    .ce_p        (ce_p),
    .m1_n        (m1_n),
    .mreq_n      (mreq_n),
    .iorq_n      (iorq_n),
    .rd_n        (rd_n),
    .wr_n        (wr_n),
    .rfsh_n      (rfsh_n),
    .a           (a),
    .ext_wait_n  (ext_wait_n),
    .cfg_en      (cfg_en),
    .cfg_wait_m1 (cfg_wait_m1),
    .cfg_wait_mem(cfg_wait_mem),
    .cfg_wait_io (cfg_wait_io),
    .cfg_wait_vdp(cfg_wait_vdp),
    .cfg_vdp_gap (cfg_vdp_gap),
    .wait_n      (wait_n),
    .acc_class   (acc_class)
  );

  always #5 clk21m = ~clk21m;
  always @(posedge clk21m) cyc <= cyc + 1;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_rng(input string nm, input int act,
                         input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d..%0d", nm, act, lo, hi);
    end
  endtask

  task automatic bus_idle();
    m1_n = 1; mreq_n = 1; iorq_n = 1;
    rd_n = 1; wr_n = 1; rfsh_n = 1;
  endtask

  task automatic set_bus(input kind_e k, input logic [7:0] ad);
    bus_idle();
    a = ad;
    case (k)
      K_M1:    begin m1_n = 0; mreq_n = 0; rd_n = 0; end
      K_MEMRD: begin mreq_n = 0; rd_n = 0; end
      K_MEMWR: begin mreq_n = 0; wr_n = 0; end
      K_IORD:  begin iorq_n = 0; rd_n = 0; end
      K_IOWR:  begin iorq_n = 0; wr_n = 0; end
      K_VDP:   begin iorq_n = 0; wr_n = 0; end
      K_RFSH:  begin mreq_n = 0; rfsh_n = 0; end
      default: begin m1_n = 0; iorq_n = 0; end
    endcase
  endtask

  // One access: strobes asserted, ce_p every 'per' clocks, ext_wait_n low
  // for the first 'ext' ce_p samples. Counts ce_p samples with wait_n low.
  task automatic run_access(input kind_e k, input logic [7:0] ad,
                            input int ext, input int per, input int mid_io,
                            output int lows, output int rel_abs,
                            output int end_cyc);
    int  ns;
    bit  fin;
    lows = 0; ns = 0; rel_abs = -1; fin = 0;
    for (int c = 0; c < 400 && !fin; c++) begin
      @(negedge clk21m);
      if (c == 0) set_bus(k, ad);
      ce_p       = (c > 0) && (c % per == 0);
      ext_wait_n = (ns < ext) ? 1'b0 : 1'b1;
      #1;
      if (c > 0 && wait_n && rel_abs < 0) rel_abs = cyc;
      if (ce_p) begin
        ns++;
        if (!wait_n) lows++;
        else fin = 1;
        if (mid_io >= 0 && ns == 1) cfg_wait_io = mid_io[2:0];
      end
    end
    if (!fin) begin
      checks++;
      failures++;
      $display("FAIL access_timeout: got no release expected release");
    end
    @(negedge clk21m);
    end_cyc = cyc;
    bus_idle();
    ce_p = 0;
    ext_wait_n = 1;
  endtask

  function automatic int model_lows(kind_e k, int m1, int mem, int io,
                                    int vdp, bit en, int ext);
    int internal;
    case (k)
      K_M1:            internal = m1;
      K_MEMRD, K_MEMWR: internal = mem;
      K_IORD, K_IOWR:  internal = io;
      K_VDP:           internal = vdp;
      default:         internal = 0;
    endcase
    if (!en) internal = 0;
    return (internal > ext) ? internal : ext;
  endfunction

  function automatic int model_cls(kind_e k);
    case (k)
      K_M1:            return 1;
      K_MEMRD, K_MEMWR: return 2;
      K_IORD, K_IOWR:  return 3;
      K_VDP:           return 4;
      default:         return -1;
    endcase
  endfunction

  task automatic set_cfg(input kind_e k, input int v);
    cfg_wait_m1  = 3'd7;
    cfg_wait_mem = 3'd7;
    cfg_wait_io  = 3'd7;
    cfg_wait_vdp = 3'd7;
    case (k)
      K_M1:            cfg_wait_m1  = v[2:0];
      K_MEMRD, K_MEMWR: cfg_wait_mem = v[2:0];
      K_IORD, K_IOWR:  cfg_wait_io  = v[2:0];
      K_VDP:           cfg_wait_vdp = v[2:0];
      default: ;
    endcase
  endtask

  task automatic pulse_reset();
    @(negedge clk21m);
    reset = 1;
    @(negedge clk21m);
    reset = 0;
  endtask

  initial begin
    int lows, rel, e1, e2, diff;
    logic [7:0] ad;
    kind_e k;
    int m1v, memv, iov, vdpv, extv, perv;
    bit env;

    tbl[0]  = '{K_M1,    1, 1'b1, 0,  4, 1,  1, "m1_fetch_1wait"};
    tbl[1]  = '{K_MEMRD, 0, 1'b1, 0,  4, 0,  2, "mem_rd_0wait"};
    tbl[2]  = '{K_MEMWR, 0, 1'b1, 0,  4, 0,  2, "mem_wr_0wait"};
    tbl[3]  = '{K_IOWR,  2, 1'b1, 0,  4, 2,  3, "out_a0_2wait"};
    tbl[4]  = '{K_VDP,   3, 1'b1, 0,  5, 3,  4, "vdp_3wait"};
    tbl[5]  = '{K_MEMRD, 2, 1'b1, 10, 3, 10, 2, "mem_ext10"};
    tbl[6]  = '{K_RFSH,  7, 1'b1, 0,  4, 0, -1, "refresh_7"};
    tbl[7]  = '{K_INTA,  7, 1'b1, 0,  4, 0, -1, "inta_7"};
    tbl[8]  = '{K_IORD,  5, 1'b0, 0,  4, 0,  3, "cfg_dis_io"};
    tbl[9]  = '{K_MEMWR, 4, 1'b0, 3,  4, 3,  2, "cfg_dis_ext3"};
    tbl[10] = '{K_M1,    7, 1'b1, 0,  2, 7,  1, "m1_7wait_fast"};

    reset = 1; ce_p = 0; a = 8'h00; ext_wait_n = 1; cfg_en = 1;
    bus_idle();
    cfg_wait_m1 = 3'd1; cfg_wait_mem = 3'd0;
    cfg_wait_io = 3'd0; cfg_wait_vdp = 3'd0; cfg_vdp_gap = 7'd0;
    repeat (3) @(negedge clk21m);
    #1;
    chk("reset_wait_n", int'(wait_n), 1);
    chk("reset_class", int'(acc_class), 0);
    @(negedge clk21m);
    reset = 0;
    repeat (2) @(negedge clk21m);

    foreach (tbl[i]) begin
      set_cfg(tbl[i].k, tbl[i].cfgv);
      cfg_en = tbl[i].en;
      ad = (tbl[i].k == K_VDP) ? 8'h9A : 8'hA0;
      run_access(tbl[i].k, ad, tbl[i].ext, tbl[i].per, -1, lows, rel, e1);
      chk(tbl[i].name, lows, tbl[i].exp_lows);
      if (tbl[i].exp_cls >= 0)
        chk({tbl[i].name, "_cls"}, int'(acc_class), tbl[i].exp_cls);
    end
    cfg_en = 1;

    // Cfg change mid I/O access applies to the next access only.
    set_cfg(K_IORD, 2);
    run_access(K_IORD, 8'hA0, 0, 4, 5, lows, rel, e1);
    chk("io_mid_change_old", lows, 2);
    run_access(K_IORD, 8'hA0, 0, 4, -1, lows, rel, e1);
    chk("io_mid_change_new", lows, 5);

    // VDP spacing: second release at least 40 clocks after first end.
    pulse_reset();
    set_cfg(K_VDP, 0);
    cfg_vdp_gap = 7'd40;
    run_access(K_VDP, 8'h98, 0, 4, -1, lows, rel, e1);
    chk("vdp_first_nogap", lows, 0);
    run_access(K_VDP, 8'h99, 0, 4, -1, lows, rel, e2);
    diff = rel - e1 - 1;
    chk_rng("vdp_gap_release", diff, 40, 42);

    // Reset while waiting releases immediately and clears gap penalty.
    @(negedge clk21m);
    set_cfg(K_MEMRD, 7);
    set_bus(K_MEMRD, 8'h00);
    repeat (4) @(negedge clk21m);
    #1;
    chk("in_wait_low", int'(wait_n), 0);
    #2;
    reset = 1;
    #1;
    chk("reset_in_wait", int'(wait_n), 1);
    chk("reset_in_wait_cls", int'(acc_class), 0);
    @(negedge clk21m);
    reset = 0;
    bus_idle();
    set_cfg(K_VDP, 0);
    run_access(K_VDP, 8'h98, 0, 4, -1, lows, rel, e1);
    chk("vdp_after_reset_nogap", lows, 0);
    cfg_vdp_gap = 7'd0;

    // Randomized accesses against the reference model.
    for (int i = 0; i < 40; i++) begin
      k    = kind_e'($urandom_range(0, 7));
      m1v  = $urandom_range(0, 7);
      memv = $urandom_range(0, 7);
      iov  = $urandom_range(0, 7);
      vdpv = $urandom_range(0, 7);
      env  = ($urandom_range(0, 3) != 0);
      extv = $urandom_range(0, 4);
      perv = $urandom_range(2, 6);
      cfg_wait_m1  = m1v[2:0];
      cfg_wait_mem = memv[2:0];
      cfg_wait_io  = iov[2:0];
      cfg_wait_vdp = vdpv[2:0];
      cfg_en = env;
      if (k == K_VDP) begin
        ad = 8'h98 | 8'($urandom_range(0, 3));
      end else begin
        ad = 8'($urandom_range(0, 255));
        if (ad[7:2] == 6'b100110) ad = ad ^ 8'h40;
      end
      run_access(k, ad, extv, perv, -1, lows, rel, e1);
      chk($sformatf("rand%0d_lows", i), lows,
          model_lows(k, m1v, memv, iov, vdpv, env, extv));
      if (model_cls(k) >= 0)
        chk($sformatf("rand%0d_cls", i), int'(acc_class), model_cls(k));
    end

    repeat (3) @(negedge clk21m);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
